cp0_ext: RTL and testbench

Parametrised coprocessor-0 for the datapath: system status, cause, EPC, PRId, BadVAddr and a Count/Compare timer. It supports a configurable number of hardware interrupt lines, each in level or edge mode, with the timer interrupt merged onto one line. It sits beside the register file, addressed by mfc0/mtc0. It raises `have2handle` to the control unit when an exception or enabled interrupt must be taken, and latches EPC/Cause on that cycle.

---
 rtl/cp0_ext.sv | 173 +++++++++++++++++
 tb/tb_cp0_ext.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_ext.sv
// cp0_ext: coprocessor 0 for the datapath.
// Holds SR, Cause, EPC, BadVAddr, PRId and a Count/Compare timer.
// Raises have2handle when an exception or an enabled interrupt must be taken.
module cp0_ext #(
    parameter int unsigned NUM_IRQ        = 6,
    parameter logic [5:0]  EDGE_MASK      = 6'b0,
    parameter int unsigned TIMER_LINE     = NUM_IRQ - 1,
    parameter int unsigned COUNT_DIV_LOG2 = 0,
    parameter logic [31:0] PRID           = 32'h0000002a
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         addr,
    input  logic               write_enable,
    input  logic [31:0]        write_data,
    input  logic               exit_isr,
    input  logic               in_bds,
    input  logic [NUM_IRQ-1:0] hwirq,
    input  logic [4:0]         exc,
    input  logic [31:0]        curr_pc,
    input  logic [31:0]        bad_vaddr_in,
    output logic [31:0]        read_result,
    output logic [31:0]        epc,
    output logic               have2handle
);

    // IM/IP are always kept 6 wide; bits for lines that do not exist stay 0
    localparam logic [5:0] LINE_MASK  = 6'b111111 >> (6 - NUM_IRQ);
    localparam logic [5:0] EDGE_LINES = EDGE_MASK & LINE_MASK;
    localparam logic [5:0] TIMER_BIT  = 6'b000001 << TIMER_LINE;
    localparam logic [3:0] DIV_MASK   = 4'b1111 >> (4 - COUNT_DIV_LOG2);

    logic [5:0]  im;
    logic [5:0]  ip;
    logic [5:0]  hw_prev;
    logic        exl;
    logic        ie;
    logic        bd;
    logic        ti;
    logic [4:0]  exc_code;
    logic [31:0] bad_vaddr;
    logic [31:0] count;
    logic [31:0] compare;
    logic [3:0]  prescaler;

    logic [5:0]  hw;
    logic [5:0]  pending;
    logic [5:0]  edge_set;
    logic [5:0]  edge_clr;
    logic [5:0]  ip_next;
    logic        wr_sr;
    logic        wr_cause;
    logic        wr_epc;
    logic        wr_count;
    logic        wr_compare;
    logic        have_exc;
    logic        have_irq;
    logic        presc_wrap;
    logic [31:0] count_next;

    assign hw = LINE_MASK & 6'(hwirq);

    // Decode writes, take conditions, and next IP / Count values
    always_comb begin
        wr_sr      = write_enable && (addr == 5'd12);
        wr_cause   = write_enable && (addr == 5'd13);
        wr_epc     = write_enable && (addr == 5'd14);
        wr_count   = write_enable && (addr == 5'd9);
        wr_compare = write_enable && (addr == 5'd11);

        pending     = ip | (ti ? TIMER_BIT : 6'b0);
        have_exc    = (exc != 5'd0) && !exl;
        have_irq    = (|(pending & im)) && ie && !exl;
        have2handle = have_exc || have_irq;

        // Edge lines latch a rising edge; a Cause write with the bit at 0 clears
        // it unless the write is dropped by a take, and a new edge beats the clear.
        edge_set = hw & ~hw_prev & EDGE_LINES;
        edge_clr = (wr_cause && !have2handle) ? (~write_data[15:10] & EDGE_LINES) : 6'b0;
        ip_next  = (hw & ~EDGE_LINES) | edge_set | (ip & EDGE_LINES & ~edge_clr);

        presc_wrap = (prescaler & DIV_MASK) == DIV_MASK;
        if (wr_count) begin
            count_next = write_data;
        end else if (presc_wrap) begin
            count_next = count + 32'd1;
        end else begin
            count_next = count;
        end
    end

    // Register read mux
    always_comb begin
        read_result = '0;
        case (addr)
            5'd8:    read_result = bad_vaddr;
            5'd9:    read_result = count;
            5'd11:   read_result = compare;
            5'd12:   read_result = {16'b0, im, 8'b0, exl, ie};
            5'd13:   read_result = {bd, ti, 14'b0, ip, 3'b0, exc_code, 2'b0};
            5'd14:   read_result = epc;
            5'd15:   read_result = PRID;
            default: read_result = '0;
        endcase
    end

    // Status, cause, EPC and BadVAddr: a take overrides any mtc0 to them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            im        <= LINE_MASK;
            exl       <= 1'b0;
            ie        <= 1'b1;
            bd        <= 1'b0;
            exc_code  <= '0;
            epc       <= '0;
            bad_vaddr <= '0;
        end else if (have2handle) begin
            exl      <= 1'b1;
            bd       <= in_bds;
            epc      <= in_bds ? (curr_pc - 32'd4) : curr_pc;
            exc_code <= have_exc ? exc : 5'd0;
            if (exc == 5'd4 || exc == 5'd5) begin
                bad_vaddr <= bad_vaddr_in;
            end
        end else begin
            if (wr_sr) begin
                im  <= write_data[15:10] & LINE_MASK;
                exl <= write_data[1];
                ie  <= write_data[0];
            end else if (exit_isr) begin
                exl <= 1'b0;
            end
            if (wr_cause) begin
                bd       <= write_data[31];
                exc_code <= write_data[6:2];
            end
            if (wr_epc) begin
                epc <= write_data;
            end
        end
    end

    // Interrupt pending bits and previous-sample history for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ip      <= '0;
            hw_prev <= '0;
        end else begin
            ip      <= ip_next;
            hw_prev <= hw;
        end
    end

    // Count/Compare timer with prescaler; a Compare write clears TI over a match
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            compare   <= '1;
            prescaler <= '0;
            ti        <= 1'b0;
        end else begin
            prescaler <= presc_wrap ? 4'd0 : (prescaler + 4'd1);
            count     <= count_next;
            if (wr_compare) begin
                compare <= write_data;
                ti      <= 1'b0;
            end else if (count_next == compare) begin
                ti <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cp0_ext.sv
// tb_cp0_ext: directed scenarios plus randomized traffic for cp0_ext,
// checked every cycle against an architectural register-word model.
module tb_cp0_ext;

    localparam logic [5:0] EDGE_LINES = 6'b000001;
    localparam int unsigned DIV_LOG2  = 2;
    localparam logic [31:0] PRID_VAL  = 32'h0000002a;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  addr = '0;
    logic        write_enable = 1'b0;
    logic [31:0] write_data = '0;
    logic        exit_isr = 1'b0;
    logic        in_bds = 1'b0;
    logic [5:0]  hwirq = '0;
    logic [4:0]  exc = '0;
    logic [31:0] curr_pc = '0;
    logic [31:0] bad_vaddr_in = '0;
    logic [31:0] read_result;
    logic [31:0] epc;
    logic        have2handle;

    int unsigned total = 0;
    int unsigned bad = 0;

    // model state: whole architectural register words
    logic [31:0] m_sr, m_cause, m_epc, m_bad, m_count, m_cmp;
    logic [5:0]  m_prev;
    int unsigned m_edges;

    cp0_ext #(
        .NUM_IRQ(6),
        .EDGE_MASK(EDGE_LINES),
        .TIMER_LINE(5),
        .COUNT_DIV_LOG2(DIV_LOG2),
        .PRID(PRID_VAL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .addr(addr),
        .write_enable(write_enable),
        .write_data(write_data),
        .exit_isr(exit_isr),
        .in_bds(in_bds),
        .hwirq(hwirq),
        .exc(exc),
        .curr_pc(curr_pc),
        .bad_vaddr_in(bad_vaddr_in),
        .read_result(read_result),
        .epc(epc),
        .have2handle(have2handle)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_bad;
            5'd9:    return m_count;
            5'd11:   return m_cmp;
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return PRID_VAL;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic exp_h2h();
        logic [5:0] pend;
        pend = m_cause[15:10] | (m_cause[30] ? 6'b100000 : 6'b000000);
        if (m_sr[1]) return 1'b0;
        return (exc != 5'd0) || (((pend & m_sr[15:10]) != 6'd0) && m_sr[0]);
    endfunction

    task automatic model_reset();
        m_sr    = 32'h0000FC01;
        m_cause = '0;
        m_epc   = '0;
        m_bad   = '0;
        m_count = '0;
        m_cmp   = 32'hFFFFFFFF;
        m_prev  = '0;
        m_edges = 0;
    endtask

    // check outputs at the falling edge, then advance the model over the rising edge
    task automatic cycle();
        logic [31:0] n_sr, n_cause, n_epc, n_bad, n_count, n_cmp;
        logic take, hexc, tick, wr;
        @(negedge clk);
        check($sformatf("read@%0d", addr), read_result, exp_read(addr));
        check("epc", epc, m_epc);
        check("have2handle", {31'b0, have2handle}, {31'b0, exp_h2h()});
        n_sr = m_sr; n_cause = m_cause; n_epc = m_epc; n_bad = m_bad; n_cmp = m_cmp;
        take = exp_h2h();
        hexc = (exc != 5'd0) && !m_sr[1];
        wr   = write_enable;
        if (take) begin
            n_sr[1]      = 1'b1;
            n_cause[31]  = in_bds;
            n_cause[6:2] = hexc ? exc : 5'd0;
            n_epc        = in_bds ? curr_pc - 32'd4 : curr_pc;
            if (exc == 5'd4 || exc == 5'd5) n_bad = bad_vaddr_in;
        end else begin
            if (wr && addr == 5'd12) n_sr = write_data & 32'h0000FC03;
            else if (exit_isr) n_sr[1] = 1'b0;
            if (wr && addr == 5'd13) begin
                n_cause[31]  = write_data[31];
                n_cause[6:2] = write_data[6:2];
            end
            if (wr && addr == 5'd14) n_epc = write_data;
        end
        for (int i = 0; i < 6; i++) begin
            if (EDGE_LINES[i]) begin
                if (hwirq[i] && !m_prev[i]) n_cause[10+i] = 1'b1;
                else if (!take && wr && addr == 5'd13 && !write_data[10+i]) n_cause[10+i] = 1'b0;
            end else begin
                n_cause[10+i] = hwirq[i];
            end
        end
        tick = ((m_edges + 1) % (1 << DIV_LOG2)) == 0;
        if (wr && addr == 5'd9) n_count = write_data;
        else if (tick) n_count = m_count + 32'd1;
        else n_count = m_count;
        if (wr && addr == 5'd11) begin
            n_cmp       = write_data;
            n_cause[30] = 1'b0;
        end else if (n_count == m_cmp) begin
            n_cause[30] = 1'b1;
        end
        @(posedge clk);
        m_sr = n_sr; m_cause = n_cause; m_epc = n_epc; m_bad = n_bad;
        m_count = n_count; m_cmp = n_cmp; m_prev = hwirq; m_edges++;
        #1;
    endtask

    task automatic probe(input logic [4:0] a);
        addr = a;
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        write_enable = 1'b1;
        addr = a;
        write_data = d;
        cycle();
        write_enable = 1'b0;
    endtask

    // assert reset partway through a cycle and check reset values while it is held
    task automatic do_reset();
        @(posedge clk);
        #3;
        write_enable = 1'b0; exit_isr = 1'b0; exc = '0; hwirq = '0; in_bds = 1'b0;
        rst = 1'b1;
        model_reset();
        addr = 5'd12; #1;
        check("rst_sr", read_result, 32'h0000FC01);
        addr = 5'd15; #1;
        check("rst_prid", read_result, 32'h0000002a);
        addr = 5'd11; #1;
        check("rst_compare", read_result, 32'hFFFFFFFF);
        check("rst_epc", epc, 32'd0);
        check("rst_h2h", {31'b0, have2handle}, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        logic [4:0] addr_tab [10];
        addr_tab = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0, 5'd10, 5'd31};

        do_reset();

        // prescaler: Count reaches 3 after 12 edges from reset
        repeat (12) cycle();
        probe(5'd9);
        check("presc_count", read_result, 32'd3);

        // exception in a branch delay slot
        exc = 5'd4; in_bds = 1'b1; curr_pc = 32'h3008; bad_vaddr_in = 32'h1001;
        probe(5'd13);
        check("bds_h2h", {31'b0, have2handle}, 32'd1);
        cycle();
        exc = '0; in_bds = 1'b0;
        probe(5'd13);
        check("bds_cause", read_result, 32'h80000010);
        check("bds_epc", epc, 32'h3004);
        check("bds_h2h_after", {31'b0, have2handle}, 32'd0);
        probe(5'd8);
        check("bds_badvaddr", read_result, 32'h1001);
        probe(5'd12);
        check("bds_sr", read_result, 32'h0000FC03);

        // edge line 0 vs level line 1, interrupts disabled
        mtc0(5'd12, 32'h0000FC00);
        hwirq = 6'b000001;
        cycle();
        hwirq = 6'b000000;
        probe(5'd13);
        check("edge_set", (read_result >> 10) & 32'd1, 32'd1);
        repeat (3) cycle();
        probe(5'd13);
        check("edge_held", (read_result >> 10) & 32'd1, 32'd1);
        mtc0(5'd13, 32'd0);
        probe(5'd13);
        check("edge_cleared", (read_result >> 10) & 32'd1, 32'd0);
        hwirq = 6'b000010;
        cycle();
        probe(5'd13);
        check("level_high", (read_result >> 11) & 32'd1, 32'd1);
        hwirq = 6'b000000;
        probe(5'd13);
        check("level_delay", (read_result >> 11) & 32'd1, 32'd1);
        cycle();
        probe(5'd13);
        check("level_low", (read_result >> 11) & 32'd1, 32'd0);

        // timer match, then Compare write clears TI
        mtc0(5'd12, 32'h0000FC01);
        mtc0(5'd11, 32'd5);
        mtc0(5'd9, 32'd0);
        addr = 5'd13;
        repeat (30) cycle();
        probe(5'd13);
        check("timer_ti", (read_result >> 30) & 32'd1, 32'd1);
        mtc0(5'd11, 32'd9);
        probe(5'd13);
        check("timer_ti_clr", (read_result >> 30) & 32'd1, 32'd0);

        // Count wrap: two ticks in eight edges after loading all ones
        mtc0(5'd9, 32'hFFFFFFFF);
        addr = 5'd9;
        repeat (8) cycle();
        probe(5'd9);
        check("count_wrap", read_result, 32'd1);

        // exception beats a pending interrupt; the interrupt fires after eret
        mtc0(5'd11, 32'h7FFFFFFF);
        mtc0(5'd12, 32'h0000FC01);
        hwirq = 6'b000001;
        cycle();
        hwirq = 6'b000000;
        exc = 5'd8;
        cycle();
        exc = '0;
        probe(5'd13);
        check("simul_exccode", (read_result >> 2) & 32'h1F, 32'd8);
        check("simul_h2h_exl", {31'b0, have2handle}, 32'd0);
        exit_isr = 1'b1;
        cycle();
        exit_isr = 1'b0;
        probe(5'd13);
        check("irq_after_eret", {31'b0, have2handle}, 32'd1);
        write_enable = 1'b1; addr = 5'd14; write_data = 32'hDEADBEEF; curr_pc = 32'h4000;
        cycle();
        write_enable = 1'b0;
        check("epc_take_wins", epc, 32'h4000);
        mtc0(5'd13, 32'd0);
        mtc0(5'd12, 32'h0000FC01);

        // randomized traffic with occasional mid-run resets
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            write_enable = ($urandom_range(0, 2) == 0);
            addr = addr_tab[$urandom_range(0, 9)];
            if (addr == 5'd9 || addr == 5'd11) write_data = $urandom_range(0, 20);
            else write_data = $urandom;
            exit_isr = ($urandom_range(0, 5) == 0);
            exc = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            in_bds = $urandom_range(0, 1) == 1;
            curr_pc = $urandom & 32'hFFFFFFFC;
            bad_vaddr_in = $urandom;
            if ($urandom_range(0, 3) == 0) hwirq[$urandom_range(0, 5)] ^= 1'b1;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
